// File: rtl/id_packet_builder_if.sv
// Decode-stage packet types and the IF/regfile/ID-EX bus bundle for id_packet_builder.
package id_packet_builder_pkg;

  localparam logic [6:0] op_lui   = 7'b0110111;
  localparam logic [6:0] op_auipc = 7'b0010111;
  localparam logic [6:0] op_jal   = 7'b1101111;
  localparam logic [6:0] op_jalr  = 7'b1100111;
  localparam logic [6:0] op_br    = 7'b1100011;
  localparam logic [6:0] op_load  = 7'b0000011;
  localparam logic [6:0] op_store = 7'b0100011;
  localparam logic [6:0] op_imm   = 7'b0010011;
  localparam logic [6:0] op_reg   = 7'b0110011;
  localparam logic [6:0] op_csr   = 7'b1110011;

  // ALU ops are encoded so that arithmetic funct3 maps straight onto them
  localparam logic [2:0] alu_add = 3'd0;
  localparam logic [2:0] alu_sll = 3'd1;
  localparam logic [2:0] alu_sra = 3'd2;
  localparam logic [2:0] alu_sub = 3'd3;
  localparam logic [2:0] alu_xor = 3'd4;
  localparam logic [2:0] alu_srl = 3'd5;
  localparam logic [2:0] alu_or  = 3'd6;
  localparam logic [2:0] alu_and = 3'd7;

  localparam logic [2:0] f3_slt  = 3'd2;
  localparam logic [2:0] f3_sltu = 3'd3;
  localparam logic [2:0] f3_add  = 3'd0;
  localparam logic [2:0] f3_sr   = 3'd5;

  localparam logic [2:0] cmp_blt  = 3'd4;
  localparam logic [2:0] cmp_bltu = 3'd6;

  localparam logic       alumux1_rs1_out = 1'b0;
  localparam logic       alumux1_pc_out  = 1'b1;

  localparam logic [2:0] alumux2_i_imm   = 3'd0;
  localparam logic [2:0] alumux2_u_imm   = 3'd1;
  localparam logic [2:0] alumux2_b_imm   = 3'd2;
  localparam logic [2:0] alumux2_s_imm   = 3'd3;
  localparam logic [2:0] alumux2_j_imm   = 3'd4;
  localparam logic [2:0] alumux2_rs2_out = 3'd5;

  localparam logic       cmpmux_rs2_out = 1'b0;
  localparam logic       cmpmux_i_imm   = 1'b1;

  localparam logic [3:0] rfmux_alu_out  = 4'd0;
  localparam logic [3:0] rfmux_br_en    = 4'd1;
  localparam logic [3:0] rfmux_u_imm    = 4'd2;
  localparam logic [3:0] rfmux_lw       = 4'd3;
  localparam logic [3:0] rfmux_pc_plus4 = 4'd4;
  localparam logic [3:0] rfmux_lb       = 4'd5;
  localparam logic [3:0] rfmux_lbu      = 4'd6;
  localparam logic [3:0] rfmux_lh       = 4'd7;
  localparam logic [3:0] rfmux_lhu      = 4'd8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] rs1_out;
    logic [31:0] rs2_out;
    logic [31:0] alu_out;
    logic        br_en;
    logic [31:0] mdrreg_out;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
  } rv32i_data_t;

  typedef struct packed {
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [6:0]  opcode;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] b_imm;
    logic [31:0] u_imm;
    logic [31:0] j_imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } rv32i_inst_t;

  typedef struct packed {
    logic       ex;
    logic       mem;
    logic       wb;
    logic [2:0] aluop;
    logic       alumux1_sel;
    logic [2:0] alumux2_sel;
    logic [2:0] cmpop;
    logic       cmpmux_sel;
    logic [3:0] regfilemux_sel;
    logic       load_regfile;
    logic       data_mem_read;
    logic       data_mem_write;
    logic [1:0] alumux1_fw;
    logic [1:0] alumux2_fw;
  } rv32i_ctrl_t;

  typedef struct packed {
    rv32i_data_t data;
    rv32i_inst_t inst;
    rv32i_ctrl_t ctrl;
  } rv32i_packet_t;

endpackage

interface id_packet_builder_if;
  import id_packet_builder_pkg::*;

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_pc;
  logic [31:0]   in_instruction;
  logic [4:0]    rf_rs1_addr;
  logic [4:0]    rf_rs2_addr;
  logic [31:0]   rf_rs1_data;
  logic [31:0]   rf_rs2_data;
  logic          out_valid;
  logic          out_ready;
  rv32i_packet_t out_packet;

  // environment side: IF stage, register file and ID/EX register
  modport master (
    output flush, in_valid, in_pc, in_instruction, rf_rs1_data, rf_rs2_data, out_ready,
    input  in_ready, rf_rs1_addr, rf_rs2_addr, out_valid, out_packet
  );

  // packet builder side
  modport slave (
    input  flush, in_valid, in_pc, in_instruction, rf_rs1_data, rf_rs2_data, out_ready,
    output in_ready, rf_rs1_addr, rf_rs2_addr, out_valid, out_packet
  );

endinterface

// File: rtl/id_packet_builder.sv
// Decode-stage packet writer: decodes the fetched instruction, captures regfile
// operands and holds the result in a 2-entry (head + skid) elastic buffer.
module id_packet_builder
  import id_packet_builder_pkg::*;
(
  input logic              clk,
  input logic              rst,
  id_packet_builder_if.slave bus
);

  rv32i_packet_t head;
  rv32i_packet_t skid;
  rv32i_packet_t new_packet;
  logic [1:0]    count;
  logic          push;
  logic          pop;
  logic [31:0]   ins;

  assign ins             = bus.in_instruction;
  assign bus.rf_rs1_addr = ins[19:15];
  assign bus.rf_rs2_addr = ins[24:20];

  // ready depends only on registered occupancy, never on out_ready
  assign bus.in_ready   = (count != 2'd2);
  assign bus.out_valid  = (count != 2'd0);
  assign bus.out_packet = head;

  assign push = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

  // decode the incoming instruction into a full packet
  always_comb begin
    new_packet = '0;

    new_packet.data.pc          = bus.in_pc;
    new_packet.data.instruction = ins;
    new_packet.data.rs1_out     = bus.rf_rs1_data;
    new_packet.data.rs2_out     = bus.rf_rs2_data;

    new_packet.inst.funct3 = ins[14:12];
    new_packet.inst.funct7 = ins[31:25];
    new_packet.inst.opcode = ins[6:0];
    new_packet.inst.rs1    = ins[19:15];
    new_packet.inst.rs2    = ins[24:20];
    new_packet.inst.rd     = ins[11:7];
    new_packet.inst.i_imm  = {{21{ins[31]}}, ins[30:20]};
    new_packet.inst.s_imm  = {{21{ins[31]}}, ins[30:25], ins[11:7]};
    new_packet.inst.b_imm  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    new_packet.inst.u_imm  = {ins[31:12], 12'h000};
    new_packet.inst.j_imm  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};

    case (ins[6:0])
      op_lui: begin
        new_packet.ctrl.wb             = 1'b1;
        new_packet.ctrl.regfilemux_sel = rfmux_u_imm;
      end
      op_auipc: begin
        new_packet.ctrl.ex             = 1'b1;
        new_packet.ctrl.wb             = 1'b1;
        new_packet.ctrl.aluop          = alu_add;
        new_packet.ctrl.alumux1_sel    = alumux1_pc_out;
        new_packet.ctrl.alumux2_sel    = alumux2_u_imm;
        new_packet.ctrl.regfilemux_sel = rfmux_alu_out;
      end
      op_jal: begin
        new_packet.ctrl.ex             = 1'b1;
        new_packet.ctrl.wb             = 1'b1;
        new_packet.ctrl.aluop          = alu_add;
        new_packet.ctrl.alumux1_sel    = alumux1_pc_out;
        new_packet.ctrl.alumux2_sel    = alumux2_j_imm;
        new_packet.ctrl.regfilemux_sel = rfmux_pc_plus4;
      end
      op_jalr: begin
        new_packet.ctrl.ex             = 1'b1;
        new_packet.ctrl.wb             = 1'b1;
        new_packet.ctrl.aluop          = alu_add;
        new_packet.ctrl.alumux1_sel    = alumux1_rs1_out;
        new_packet.ctrl.alumux2_sel    = alumux2_i_imm;
        new_packet.ctrl.regfilemux_sel = rfmux_pc_plus4;
      end
      op_br: begin
        new_packet.ctrl.ex          = 1'b1;
        new_packet.ctrl.aluop       = alu_add;
        new_packet.ctrl.alumux1_sel = alumux1_pc_out;
        new_packet.ctrl.alumux2_sel = alumux2_b_imm;
        new_packet.ctrl.cmpop       = ins[14:12];
        new_packet.ctrl.cmpmux_sel  = cmpmux_rs2_out;
      end
      op_load: begin
        new_packet.ctrl.ex            = 1'b1;
        new_packet.ctrl.mem           = 1'b1;
        new_packet.ctrl.wb            = 1'b1;
        new_packet.ctrl.data_mem_read = 1'b1;
        new_packet.ctrl.aluop         = alu_add;
        new_packet.ctrl.alumux1_sel   = alumux1_rs1_out;
        new_packet.ctrl.alumux2_sel   = alumux2_i_imm;
        case (ins[14:12])
          3'b000:  new_packet.ctrl.regfilemux_sel = rfmux_lb;
          3'b001:  new_packet.ctrl.regfilemux_sel = rfmux_lh;
          3'b100:  new_packet.ctrl.regfilemux_sel = rfmux_lbu;
          3'b101:  new_packet.ctrl.regfilemux_sel = rfmux_lhu;
          default: new_packet.ctrl.regfilemux_sel = rfmux_lw;
        endcase
      end
      op_store: begin
        new_packet.ctrl.ex             = 1'b1;
        new_packet.ctrl.mem            = 1'b1;
        new_packet.ctrl.data_mem_write = 1'b1;
        new_packet.ctrl.aluop          = alu_add;
        new_packet.ctrl.alumux1_sel    = alumux1_rs1_out;
        new_packet.ctrl.alumux2_sel    = alumux2_s_imm;
      end
      op_imm, op_reg: begin
        new_packet.ctrl.ex             = 1'b1;
        new_packet.ctrl.wb             = 1'b1;
        new_packet.ctrl.alumux1_sel    = alumux1_rs1_out;
        new_packet.ctrl.alumux2_sel    = (ins[6:0] == op_reg) ? alumux2_rs2_out : alumux2_i_imm;
        new_packet.ctrl.aluop          = ins[14:12];
        new_packet.ctrl.regfilemux_sel = rfmux_alu_out;
        if (ins[14:12] == f3_slt || ins[14:12] == f3_sltu) begin
          new_packet.ctrl.cmpop          = (ins[14:12] == f3_slt) ? cmp_blt : cmp_bltu;
          new_packet.ctrl.cmpmux_sel     = (ins[6:0] == op_reg) ? cmpmux_rs2_out : cmpmux_i_imm;
          new_packet.ctrl.regfilemux_sel = rfmux_br_en;
        end else if (ins[14:12] == f3_sr && ins[30]) begin
          new_packet.ctrl.aluop = alu_sra;
        end else if (ins[14:12] == f3_add && ins[30] && ins[6:0] == op_reg) begin
          new_packet.ctrl.aluop = alu_sub;
        end
      end
      default: ;
    endcase

    // writes to x0 are squashed here so later stages never see them
    if (ins[11:7] == 5'd0) new_packet.ctrl.wb = 1'b0;
    new_packet.ctrl.load_regfile = new_packet.ctrl.wb;
  end

  // head/skid buffer; a push with simultaneous pop can only occur at count 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 2'd0;
      head  <= '0;
      skid  <= '0;
    end else if (bus.flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= new_packet;
          else               skid <= new_packet;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= skid;
          count <= count - 2'd1;
        end
        2'b11: head <= new_packet;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_id_packet_builder.sv
// Directed bench for id_packet_builder: decode fields, buffer flow, flush and async reset.
module tb_id_packet_builder;
  import id_packet_builder_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  id_packet_builder_if bus ();

  id_packet_builder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins);
    bus.in_valid       = 1'b1;
    bus.in_pc          = pc;
    bus.in_instruction = ins;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst                = 1'b0;
    bus.flush          = 1'b0;
    bus.in_valid       = 1'b0;
    bus.in_pc          = '0;
    bus.in_instruction = '0;
    bus.rf_rs1_data    = '0;
    bus.rf_rs2_data    = '0;
    bus.out_ready      = 1'b0;

    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_pkt_zero", 32'(|bus.out_packet), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // addi x1,x0,5
    drive(32'h60, 32'h00500093);
    #1;
    chk("addi_rs1_addr", 32'(bus.rf_rs1_addr), 32'd0);
    chk("addi_rs2_addr", 32'(bus.rf_rs2_addr), 32'd5);
    step();
    bus.in_valid = 1'b0;
    chk("addi_out_valid", 32'(bus.out_valid), 32'd1);
    chk("addi_opcode", 32'(bus.out_packet.inst.opcode), 32'h13);
    chk("addi_i_imm", bus.out_packet.inst.i_imm, 32'd5);
    chk("addi_rd", 32'(bus.out_packet.inst.rd), 32'd1);
    chk("addi_aluop", 32'(bus.out_packet.ctrl.aluop), 32'(alu_add));
    chk("addi_alumux2", 32'(bus.out_packet.ctrl.alumux2_sel), 32'(alumux2_i_imm));
    chk("addi_load_rf", 32'(bus.out_packet.ctrl.load_regfile), 32'd1);
    chk("addi_pc", bus.out_packet.data.pc, 32'h60);
    chk("addi_rfmux", 32'(bus.out_packet.ctrl.regfilemux_sel), 32'(rfmux_alu_out));
    bus.out_ready = 1'b1;
    step();
    chk("addi_popped", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // stream four with out_ready low, then drain
    drive(32'h100, 32'h00100093);
    step();
    chk("s0_in_ready", 32'(bus.in_ready), 32'd1);
    drive(32'h104, 32'h00200113);
    step();
    chk("s1_in_ready_full", 32'(bus.in_ready), 32'd0);
    drive(32'h108, 32'h00300193);
    step();
    chk("s2_blocked", 32'(bus.in_ready), 32'd0);
    chk("s2_head_stable", bus.out_packet.data.pc, 32'h100);
    bus.out_ready = 1'b1;
    step();
    chk("s_pop1_pc", bus.out_packet.data.pc, 32'h104);
    chk("s_pop1_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("s_pushpop_pc", bus.out_packet.data.pc, 32'h108);
    drive(32'h10C, 32'h00400213);
    step();
    chk("s_last_pc", bus.out_packet.data.pc, 32'h10C);
    chk("s_last_ins", bus.out_packet.data.instruction, 32'h00400213);
    bus.in_valid = 1'b0;
    step();
    chk("s_drained", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // sw x2,-4(x1)
    drive(32'h200, 32'hFE20AE23);
    bus.rf_rs1_data = 32'h100;
    bus.rf_rs2_data = 32'hAB;
    #1;
    chk("sw_rs1_addr", 32'(bus.rf_rs1_addr), 32'd1);
    chk("sw_rs2_addr", 32'(bus.rf_rs2_addr), 32'd2);
    step();
    bus.rf_rs1_data = '0;
    bus.rf_rs2_data = '0;
    chk("sw_s_imm", bus.out_packet.inst.s_imm, 32'hFFFFFFFC);
    chk("sw_rs1_out", bus.out_packet.data.rs1_out, 32'h100);
    chk("sw_rs2_out", bus.out_packet.data.rs2_out, 32'hAB);
    chk("sw_dmw", 32'(bus.out_packet.ctrl.data_mem_write), 32'd1);
    chk("sw_wb", 32'(bus.out_packet.ctrl.wb), 32'd0);
    chk("sw_alumux2", 32'(bus.out_packet.ctrl.alumux2_sel), 32'(alumux2_s_imm));

    // fill to 2, then flush with input and pop attempt
    drive(32'h204, 32'h00000033);
    step();
    chk("fl_full", 32'(bus.in_ready), 32'd0);
    drive(32'h300, 32'hDEADBEEF);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("fl_still_empty", 32'(bus.out_valid), 32'd0);

    // add x0,x0,x0
    drive(32'h400, 32'h00000033);
    step();
    chk("x0_load_rf", 32'(bus.out_packet.ctrl.load_regfile), 32'd0);
    chk("x0_ex", 32'(bus.out_packet.ctrl.ex), 32'd1);

    // unknown opcode via push+pop at count 1
    drive(32'h404, 32'h0000007F);
    bus.out_ready = 1'b1;
    step();
    chk("unk_out_valid", 32'(bus.out_valid), 32'd1);
    chk("unk_pc", bus.out_packet.data.pc, 32'h404);
    chk("unk_enables", 32'({bus.out_packet.ctrl.ex, bus.out_packet.ctrl.mem, bus.out_packet.ctrl.wb,
                            bus.out_packet.ctrl.load_regfile, bus.out_packet.ctrl.data_mem_read,
                            bus.out_packet.ctrl.data_mem_write}), 32'd0);

    // sub x2,x1,x2
    drive(32'h408, 32'h40208133);
    step();
    chk("sub_aluop", 32'(bus.out_packet.ctrl.aluop), 32'(alu_sub));
    chk("sub_alumux2", 32'(bus.out_packet.ctrl.alumux2_sel), 32'(alumux2_rs2_out));

    // srai x1,x1,3
    drive(32'h40C, 32'h4030D093);
    step();
    chk("srai_aluop", 32'(bus.out_packet.ctrl.aluop), 32'(alu_sra));
    chk("srai_i_imm", bus.out_packet.inst.i_imm, 32'h403);
    bus.in_valid = 1'b0;
    step();
    chk("srai_drained", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // async reset with count 2
    drive(32'h500, 32'h00100093);
    step();
    drive(32'h504, 32'h00200113);
    step();
    bus.in_valid = 1'b0;
    chk("ar_full", 32'(bus.in_ready), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_out_valid", 32'(bus.out_valid), 32'd0);
    chk("ar_in_ready", 32'(bus.in_ready), 32'd1);
    chk("ar_pkt_zero", 32'(|bus.out_packet), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("ar_stays_empty", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_packet_builder.md
# id_packet_builder

Decode-stage packet writer for the pipelined RV32I core. Accepts raw fetched instructions (pc + instruction word) from IF and reads rs1/rs2 from the register file. Builds the full `rv32i_packet_t` (data, inst, ctrl sections) and holds it in a 2-entry elastic buffer. The buffer feeds the ID/EX pipeline register through a valid/ready handshake, with flush support for branch redirects.

## Interface
- No parameters; buffer depth is fixed at 2 entries (main + skid).
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `flush`  in  1  discard all buffered packets and any same-cycle input
- `in_valid`  in  1  IF presents an instruction
- `in_ready`  out  1  block can accept this cycle
- `in_pc`  in  32  fetch PC
- `in_instruction`  in  32  raw instruction word
- `rf_rs1_addr`, `rf_rs2_addr`  out  5 each  equal to `in_instruction[19:15]` / `[24:20]`, combinational
- `rf_rs1_data`, `rf_rs2_data`  in  32 each  combinational regfile read data (regfile provides write-through)
- `out_valid`  out  1  head packet valid
- `out_ready`  in  1  ID/EX accepts head packet
- `out_packet`  out  `rv32i_packet_t`  head packet

## Operation
- Accept on `in_valid && in_ready && !flush`. Decode and regfile capture occur in the accept cycle; the packet is written into the tail entry.
- inst section: funct3 `[14:12]`, funct7 `[31:25]`, opcode `[6:0]`, rs1/rs2/rd, all five immediates (standard RV32I sign extension).
- data section: pc, instruction, rs1_out/rs2_out from regfile; alu_out, br_en, mdrreg_out, rmask, wmask = 0.
- ctrl section, per opcode:
  - op_lui: wb, regfilemux u_imm.
  - op_auipc: ex, alu_add, pc_out/u_imm, regfilemux alu_out.
  - op_jal: ex, alu_add, pc_out/j_imm, regfilemux pc_plus4.
  - op_jalr: ex, alu_add, rs1_out/i_imm, regfilemux pc_plus4.
  - op_br: ex, alu_add, pc_out/b_imm, cmpop = funct3, cmpmux rs2_out, wb = 0.
  - op_load: ex, mem, data_mem_read, alu_add, rs1_out/i_imm. regfilemux by funct3: lb, lh, lw, lbu, lhu.
  - op_store: ex, mem, data_mem_write, alu_add, rs1_out/s_imm, wb = 0.
  - op_imm: ex, rs1_out/i_imm, aluop = funct3 with these exceptions:
    - slti → cmpop blt, cmpmux i_imm, regfilemux br_en
    - sltiu → cmpop bltu, cmpmux i_imm, regfilemux br_en
    - srai (funct7[5]) → alu_sra
    - all other cases → regfilemux alu_out
  - op_reg: as op_imm with alumux2 rs2_out and cmpmux rs2_out. funct7[5] selects alu_sub (add) / alu_sra (sr).
- `load_regfile` = `wb` = 1 for lui/auipc/jal/jalr/load/imm/reg, forced 0 when rd == 0.
- Unknown opcode or op_csr: every ctrl enable is 0 (packet passes as NOP).
- Forward fields (`alumux1_fw`, `alumux2_fw`) are always 0; the forwarding unit overwrites them downstream.
- Buffer: head register plus skid register, 2-bit count.
  - `in_ready = (count != 2)`, driven from registered state only; no combinational path from `out_ready`.
  - `out_valid = (count != 0)`.
  - Pop on `out_valid && out_ready`. Simultaneous push and pop at count 1 keeps count 1; the new packet becomes head.
- `flush`: count → 0 at the next edge, same-cycle input dropped, same-cycle pop ignored.

## Timing
- Reset (asynchronous, `rst` low): count = 0, both entries cleared to all-zero packet. Outputs while in reset: `out_valid` = 0, `in_ready` = 1, `out_packet` = 0.
- Latency: instruction accepted at edge N appears on `out_packet` with `out_valid` = 1 after edge N (visible in cycle N+1).
- Throughput: one packet per cycle when `out_ready` is held high.
- `out_packet` is held stable while `out_valid && !out_ready`.
- Order is preserved FIFO.
- `rst` assertion mid-transfer empties the buffer immediately, without waiting for a clock edge.
- Count never exceeds 2 and never underflows: a pop at count 0 is ignored.

## Test plan
- After reset, `in_valid` = 1 with `0x00500093` (addi x1,x0,5), pc `0x60` → next cycle `out_valid` = 1 with:
  - opcode op_imm, i_imm 5, rd 1
  - aluop alu_add, alumux2 i_imm
  - load_regfile 1, pc `0x60`
- Stream 4 instructions with `out_ready` = 0 → `in_ready` drops after 2 accepts. Raise `out_ready` → packets emerge in order, none lost or duplicated.
- `0xFE20AE23` (sw x2,-4(x1)) with rf data `0x100` / `0xAB` → s_imm `0xFFFFFFFC`, rs1_out `0x100`, rs2_out `0xAB`, data_mem_write 1, wb 0.
- `flush` with count 2 and `in_valid` high → next cycle `out_valid` = 0, count 0, flushed input never appears.
- `0x00000033` (add x0,x0,x0) → load_regfile 0. Opcode `0x7F` → all ctrl enables 0.
- `rst` low mid-stream with count 2 → `out_valid` = 0 immediately (asynchronously), `in_ready` = 1.
